lcd_draw_arbiter: RTL and testbench

LCD_DRAW_ARBITER -- requirements
Module: lcd_draw_arbiter

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_rr_arb2.sv | 25 ++
 rtl/lcd_draw_arbiter.sv | 152 +++++++++++++++
 tb/tb_lcd_draw_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD draw arbiter: command layout,
// panel limits and controller state encoding.
package lcd_pkg;

  localparam int X_W     = 8;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 16;  // RGB565
  localparam int CMD_W   = 2 * X_W + 2 * Y_W + COLOR_W;

  // Bit offsets of each field inside a 50-bit command word
  localparam int COLOR_LSB = 0;
  localparam int Y2_LSB    = COLOR_LSB + COLOR_W;
  localparam int Y1_LSB    = Y2_LSB + Y_W;
  localparam int X2_LSB    = Y1_LSB + Y_W;
  localparam int X1_LSB    = X2_LSB + X_W;

  localparam int X_MAX_DEF = 239;
  localparam int Y_MAX_DEF = 319;

  typedef struct packed {
    logic [X_W-1:0]     x1;
    logic [X_W-1:0]     x2;
    logic [Y_W-1:0]     y1;
    logic [Y_W-1:0]     y2;
    logic [COLOR_W-1:0] color;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_INIT_REQ,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last requester served.
module lcd_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;
  logic pick;

  // On contention the requester not served last time wins.
  assign pick = (req == 2'b11) ? ~last : req[1];
  assign gnt  = (en && (req != 2'b00)) ? (pick ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/lcd_draw_arbiter.sv
// Arbitrates two draw requesters onto one rectangle fill engine, after panel
// init, with coordinate normalisation, done timeouts and inter-job gaps.
module lcd_draw_arbiter
  import lcd_pkg::*;
#(
  parameter int GAP     = 20,
  parameter int TIMEOUT = 2000000,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req,
  input  logic [CMD_W-1:0]   i_cmd0,
  input  logic [CMD_W-1:0]   i_cmd1,
  output logic [1:0]         o_gnt,
  output logic               o_init_start,
  input  logic               i_init_done,
  output logic               o_eng_start,
  output logic [X_W-1:0]     o_x1,
  output logic [X_W-1:0]     o_x2,
  output logic [Y_W-1:0]     o_y1,
  output logic [Y_W-1:0]     o_y2,
  output logic [COLOR_W-1:0] o_color,
  input  logic               i_eng_done,
  output logic               o_busy,
  output logic               o_err
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  state_t           state, state_nxt, after_wait;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             tmo, gap_last, set_err, err, arb_en;
  logic [1:0]       gnt;
  cmd_t             job, norm, cmd_sel;
  logic [X_W-1:0]   x_lo, x_hi;
  logic [Y_W-1:0]   y_lo, y_hi;

  assign arb_en = (state == ST_IDLE) && !i_rst;

  lcd_rr_arb2 u_arb (
    .clk (i_clk),
    .rst (i_rst),
    .req (i_req),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign cmd_sel = gnt[1] ? cmd_t'(i_cmd1) : cmd_t'(i_cmd0);

  // Order each axis first, then clamp both ends to the panel limits.
  assign x_lo       = (job.x1 > job.x2) ? job.x2 : job.x1;
  assign x_hi       = (job.x1 > job.x2) ? job.x1 : job.x2;
  assign y_lo       = (job.y1 > job.y2) ? job.y2 : job.y1;
  assign y_hi       = (job.y1 > job.y2) ? job.y1 : job.y2;
  assign norm.x1    = (x_lo > X_LIM) ? X_LIM : x_lo;
  assign norm.x2    = (x_hi > X_LIM) ? X_LIM : x_hi;
  assign norm.y1    = (y_lo > Y_LIM) ? Y_LIM : y_lo;
  assign norm.y2    = (y_hi > Y_LIM) ? Y_LIM : y_hi;
  assign norm.color = job.color;

  assign tmo        = (timer == TMR_W'(TIMEOUT - 1));
  assign gap_last   = (gap_cnt == GAP_W'(GAP - 1));
  assign after_wait = (GAP == 0) ? ST_IDLE : ST_GAP;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    set_err      = 1'b0;
    o_init_start = 1'b0;
    o_eng_start  = 1'b0;
    unique case (state)
      ST_INIT_REQ: begin
        o_init_start = 1'b1;
        state_nxt    = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (i_init_done) begin
          state_nxt = after_wait;
        end else if (tmo) begin
          set_err   = 1'b1;
          state_nxt = after_wait;
        end
      end
      ST_IDLE:  if (i_req != 2'b00) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_START;
      ST_START: begin
        o_eng_start = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_eng_done) begin
          state_nxt = after_wait;
        end else if (tmo) begin
          set_err   = 1'b1;
          state_nxt = after_wait;
        end
      end
      ST_GAP:   if (gap_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT_REQ;
    endcase
    if (i_rst) begin
      o_init_start = 1'b0;
      o_eng_start  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_INIT_REQ;
      timer   <= '0;
      gap_cnt <= '0;
      err     <= 1'b0;
      job     <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        timer <= '0;
      end else if (state == ST_WAIT || state == ST_INIT_WAIT) begin
        timer <= timer + 1'b1;
      end
      if (state_nxt != state) begin
        gap_cnt <= '0;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (set_err) err <= 1'b1;
      // Raw command lands on grant; LOAD rewrites it in normalised form.
      if (gnt != 2'b00) begin
        job <= cmd_sel;
      end else if (state == ST_LOAD) begin
        job <= norm;
      end
    end
  end

  assign o_gnt   = gnt;
  assign o_x1    = job.x1;
  assign o_x2    = job.x2;
  assign o_y1    = job.y1;
  assign o_y2    = job.y2;
  assign o_color = job.color;
  assign o_busy  = (state != ST_IDLE);
  assign o_err   = err;

endmodule

// File: tb/tb_lcd_draw_arbiter.sv
// Randomised self-checking bench for lcd_draw_arbiter against a
// request-level model of arbitration, normalisation and job timing.
module tb_lcd_draw_arbiter;

  localparam int GAP     = 6;
  localparam int TIMEOUT = 50;
  localparam int XM      = 239;
  localparam int YM      = 319;
  localparam int NJOBS   = 20;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req;
  logic [49:0] i_cmd0, i_cmd1;
  logic [1:0]  o_gnt;
  logic        o_init_start, i_init_done, o_eng_start, i_eng_done, o_busy, o_err;
  logic [7:0]  o_x1, o_x2;
  logic [8:0]  o_y1, o_y2;
  logic [15:0] o_color;

  lcd_draw_arbiter #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        (i_req),
    .i_cmd0       (i_cmd0),
    .i_cmd1       (i_cmd1),
    .o_gnt        (o_gnt),
    .o_init_start (o_init_start),
    .i_init_done  (i_init_done),
    .o_eng_start  (o_eng_start),
    .o_x1         (o_x1),
    .o_x2         (o_x2),
    .o_y1         (o_y1),
    .o_y2         (o_y2),
    .o_color      (o_color),
    .i_eng_done   (i_eng_done),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  pending;
  int          last;
  logic        exp_err;
  int          addn = 0;
  int          jobn;
  logic [49:0] cmd_v [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start a new cycle; done pulses last exactly one cycle unless re-driven.
  task automatic tick();
    @(posedge i_clk);
    #1;
    i_eng_done  = 1'b0;
    i_init_done = 1'b0;
  endtask

  function automatic logic [49:0] norm_model(input logic [49:0] c);
    int x1, x2, y1, y2, t;
    x1 = int'(c[49:42]);
    x2 = int'(c[41:34]);
    y1 = int'(c[33:25]);
    y2 = int'(c[24:16]);
    if (x1 > x2) begin t = x1; x1 = x2; x2 = t; end
    if (y1 > y2) begin t = y1; y1 = y2; y2 = t; end
    if (x1 > XM) x1 = XM;
    if (x2 > XM) x2 = XM;
    if (y1 > YM) y1 = YM;
    if (y2 > YM) y2 = YM;
    return {8'(x1), 8'(x2), 9'(y1), 9'(y2), c[15:0]};
  endfunction

  function automatic logic [49:0] rand_cmd();
    return {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 16'($urandom)};
  endfunction

  // New requesters join; a requester already waiting keeps its command.
  task automatic add_requests();
    logic [1:0] add;
    case (addn)
      0, 1:       add = 2'b01;
      2, 3, 4, 5: add = 2'b11;
      default: begin
        add = 2'($urandom_range(0, 3));
        if ((pending | add) == 2'b00) add = 2'($urandom_range(1, 3));
      end
    endcase
    for (int r = 0; r < 2; r++) begin
      if (add[r] && !pending[r]) begin
        cmd_v[r] = rand_cmd();
        if (addn == 0 && r == 0) cmd_v[0] = {8'd15, 8'd10, 9'd10, 9'd15, 16'hF800};
        if (addn == 1 && r == 0) cmd_v[0] = {8'd5, 8'd250, 9'd20, 9'd400, 16'h07E0};
      end
    end
    pending = pending | add;
    i_cmd0  = cmd_v[0];
    i_cmd1  = cmd_v[1];
    i_req   = pending;
    addn++;
  endtask

  // Counts idle cycles before the next grant, with stray done pulses thrown in.
  task automatic wait_gnt(output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if ($urandom_range(0, 5) == 0) i_eng_done = 1'b1;
      if ($urandom_range(0, 5) == 0) i_init_done = 1'b1;
      @(negedge i_clk);
      if (o_gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  // Releases reset, answers init 5 cycles after the start pulse, waits for the first grant.
  task automatic do_init(output logic ok);
    int n;
    int bad;
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("init_start_pulse", o_init_start, 1);
    check("init_busy", o_busy, 1);
    check("init_err", o_err, 0);
    check("init_gnt", o_gnt, 0);
    check("init_job_x1", o_x1, 0);
    check("init_job_color", o_color, 0);
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) i_eng_done = 1'b1;
      if (k == 5) i_init_done = 1'b1;
      @(negedge i_clk);
      if (o_gnt != 2'b00 || !o_busy || o_init_start) bad++;
    end
    check("init_wait_quiet", 64'(bad), 0);
    wait_gnt(n, ok);
    check("init_gnt_seen", ok, 1);
    check("init_gap_cycles", 64'(n), 64'(GAP));
  endtask

  // Entered on the grant cycle; runs the job through done or timeout to the next grant.
  task automatic do_job(input bit tmo, output logic ok);
    int          w, d, n, exp_n;
    logic [49:0] expn;
    w = (pending == 2'b11) ? ((last == 0) ? 1 : 0) : (pending[1] ? 1 : 0);
    check("gnt_pick", o_gnt, (w == 1) ? 2'b10 : 2'b01);
    check("gnt_idle_busy", o_busy, 0);
    check("gnt_err", o_err, exp_err);
    expn       = norm_model(cmd_v[w]);
    last       = w;
    pending[w] = 1'b0;
    tick();
    i_req = pending;
    @(negedge i_clk);
    check("load_no_start", o_eng_start, 0);
    check("load_no_gnt", o_gnt, 0);
    tick();
    @(negedge i_clk);
    check("eng_start_lat2", o_eng_start, 1);
    check("job_norm", {o_x1, o_x2, o_y1, o_y2, o_color}, expn);
    if (jobn == 0) check("dir_norm", {o_x1, o_x2, o_y1, o_y2, o_color},
                         {8'd10, 8'd15, 9'd10, 9'd15, 16'hF800});
    if (jobn == 1) begin
      check("clamp_x2", o_x2, 239);
      check("clamp_y2", o_y2, 319);
    end
    if (!tmo) begin
      d = $urandom_range(0, 8);
      for (int k = 0; k <= d; k++) begin
        tick();
        if (k == d) begin
          i_eng_done = 1'b1;
          add_requests();
        end
        @(negedge i_clk);
        if (k == d) begin
          check("job_hold", {o_x1, o_x2, o_y1, o_y2, o_color}, expn);
          check("wait_busy", o_busy, 1);
        end
      end
      exp_n = GAP;
    end else begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        tick();
        if (k == TIMEOUT) add_requests();
        @(negedge i_clk);
        if (k == TIMEOUT) check("err_before_tmo", o_err, exp_err);
      end
      tick();
      @(negedge i_clk);
      exp_err = 1'b1;
      check("err_at_tmo", o_err, 1);
      check("gap_busy", o_busy, 1);
      exp_n = GAP - 1;
    end
    wait_gnt(n, ok);
    check("next_gnt_seen", ok, 1);
    check("gap_cycles", 64'(n), 64'(exp_n));
  endtask

  initial begin
    logic ok;
    i_rst = 1'b1; i_req = '0; i_cmd0 = '0; i_cmd1 = '0;
    i_init_done = 1'b0; i_eng_done = 1'b0;
    pending = '0; last = 1; exp_err = 1'b0;
    cmd_v[0] = '0; cmd_v[1] = '0;
    repeat (3) tick();
    @(negedge i_clk);
    check("rst_gnt", o_gnt, 0);
    check("rst_init_start", o_init_start, 0);
    check("rst_eng_start", o_eng_start, 0);
    check("rst_err", o_err, 0);
    check("rst_busy", o_busy, 1);
    check("rst_x2", o_x2, 0);
    add_requests();
    do_init(ok);
    if (ok) begin
      for (jobn = 0; jobn < NJOBS; jobn++) begin
        do_job(jobn == 6 || jobn == 13, ok);
        if (!ok) break;
      end
    end
    if (ok) begin
      // Abandon a job mid-WAIT with reset; both then request and requester 0 must win.
      tick();
      i_req   = 2'b00;
      pending = 2'b00;
      repeat (4) tick();
      tick();
      i_rst    = 1'b1;
      last     = 1;
      exp_err  = 1'b0;
      cmd_v[0] = rand_cmd();
      cmd_v[1] = rand_cmd();
      pending  = 2'b11;
      i_cmd0   = cmd_v[0];
      i_cmd1   = cmd_v[1];
      i_req    = pending;
      @(negedge i_clk);
      check("rst_mid_eng_start", o_eng_start, 0);
      check("rst_mid_gnt", o_gnt, 0);
      do_init(ok);
      jobn = NJOBS;
      if (ok) do_job(1'b0, ok);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
